// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if -- bundles the two sides of the data-cache controller.
//
//   Pipeline side : memread, memwrite, f3, addr, wdata  (to cache)
//                   rdata, memhazard                    (from cache)
//   Memory side   : mem_req, mem_we, mem_addr,
//                   mem_wdata, mem_wstrb                (from cache)
//                   mem_rdata, mem_ack                  (to cache)
//
//   slave  : the cache controller's view
//   master : the environment's view (pipeline + backing memory)
interface dcache_ctrl_if;
    logic        memread;
    logic        memwrite;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        memhazard;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  memread, memwrite, f3, addr, wdata, mem_rdata, mem_ack,
        output rdata, memhazard, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output memread, memwrite, f3, addr, wdata, mem_rdata, mem_ack,
        input  rdata, memhazard, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- 16-line direct-mapped, one-word-per-line data cache
// controller, write-through / no-write-allocate.
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : dcache_ctrl_if.slave (pipeline request/result and backing memory
//          request/ack signals, see the interface file)
//
// Lines are indexed by addr[5:2] and tagged with addr[31:6]. Load hits
// return data combinationally with no stall. Misses and all stores stall the
// pipeline through memhazard until the memory acks.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; hits served combinationally
// RMISS | read request outstanding, fill line on ack
// WRITE | write-through request outstanding, merge into line on hit
// DONE  | one cycle of release; pipeline takes the result, no request
module dcache_ctrl (
    input  logic          clk,
    input  logic          rst,
    dcache_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RMISS = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [31:0] line_data  [16];
    logic [25:0] line_tag   [16];
    logic [15:0] line_valid;

    logic [3:0]  idx;
    logic        hit;
    logic [3:0]  m_idx;
    logic        m_hit;
    logic        ack_take;
    logic        start_rd;
    logic        start_wr;

    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;

    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign idx = bus.addr[5:2];
    assign hit = line_valid[idx] && (line_tag[idx] == bus.addr[31:6]);

    // Fill/merge uses the registered request address, which is held stable
    // for the whole transaction.
    assign m_idx = bus.mem_addr[5:2];
    assign m_hit = line_valid[m_idx] && (line_tag[m_idx] == bus.mem_addr[31:6]);

    // An ack only counts while a request is outstanding.
    assign ack_take = bus.mem_req && bus.mem_ack;

    // Store lane formatting.
    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = bus.wdata;
        case (bus.f3)
            3'b000: begin
                st_wstrb = 4'b0001 << bus.addr[1:0];
                st_wdata = {4{bus.wdata[7:0]}};
            end
            3'b001: begin
                st_wstrb = 4'b0011 << {bus.addr[1], 1'b0};
                st_wdata = {2{bus.wdata[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = bus.wdata;
            end
        endcase
    end

    // Load extraction and extension.
    always_comb begin
        rd_word = line_data[idx];
        case (bus.addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (bus.f3)
            3'b000:  bus.rdata = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  bus.rdata = {{16{rd_half[15]}}, rd_half};
            3'b100:  bus.rdata = {24'd0, rd_byte};
            3'b101:  bus.rdata = {16'd0, rd_half};
            default: bus.rdata = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A store wins over a simultaneous load.
    always_comb begin
        state_nxt     = state;
        bus.memhazard = 1'b0;
        start_rd      = 1'b0;
        start_wr      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.memwrite) begin
                    bus.memhazard = 1'b1;
                    start_wr      = 1'b1;
                    state_nxt     = WRITE;
                end else if (bus.memread && !hit) begin
                    bus.memhazard = 1'b1;
                    start_rd      = 1'b1;
                    state_nxt     = RMISS;
                end
            end
            RMISS: begin
                bus.memhazard = 1'b1;
                if (ack_take) begin
                    state_nxt = DONE;
                end
            end
            WRITE: begin
                bus.memhazard = 1'b1;
                if (ack_take) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory request registers: loaded on the edge that leaves IDLE, so the
    // request is visible in the first RMISS/WRITE cycle and held until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
        end else if (start_rd || start_wr) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= start_wr;
            bus.mem_addr  <= {bus.addr[31:2], 2'b00};
            bus.mem_wdata <= start_wr ? st_wdata : 32'd0;
            bus.mem_wstrb <= start_wr ? st_wstrb : 4'd0;
        end else if (ack_take) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid <= '0;
        end else if (ack_take && state == RMISS) begin
            line_valid[m_idx] <= 1'b1;
        end
    end

    // Data and tag arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (!rst && ack_take) begin
            if (state == RMISS) begin
                line_data[m_idx] <= bus.mem_rdata;
                line_tag[m_idx]  <= bus.mem_addr[31:6];
            end else if (state == WRITE && m_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_wstrb[b]) begin
                        line_data[m_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule
